// File: rtl/iomem_gpio_timer_if.sv
// PicoRV32 iomem bus bundle: CPU (master) drives the request, peripheral (slave) answers.
interface iomem_gpio_timer_if;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;

  modport master (output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
                  input  iomem_ready, iomem_rdata);
  modport slave  (input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
                  output iomem_ready, iomem_rdata);
endinterface

// File: rtl/iomem_gpio_timer.sv
// iomem peripheral in a 256-byte window: porta output register, synchronized portb with
// edge-triggered pending bits, and a 32-bit compare timer, each with a level interrupt.
module iomem_gpio_timer #(
  parameter logic [31:0] BASE_ADDR   = 32'h0300_0000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  iomem_gpio_timer_if.slave   bus,
  output logic [7:0]          porta_out,
  input  logic [7:0]          portb_in,
  output logic                irq_gpio,
  output logic                irq_timer
);

  logic                          ready_q;
  logic [31:0]                   rdata_q;
  logic [7:0]                    porta_q, porta_d;
  logic [7:0]                    ie_q, ie_d;
  logic [7:0]                    edge_q, edge_d;
  logic [7:0]                    pend_q, pend_d;
  logic                          ten_q, ten_d;
  logic                          tirqen_q, tirqen_d;
  logic                          tpend_q, tpend_d;
  logic [31:0]                   cmp_q, cmp_d;
  logic [31:0]                   cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0][7:0]   sync_q;
  logic [7:0]                    hist_q;
  logic                          irq_gpio_q, irq_timer_q;

  logic        hit, wr, match;
  logic [5:0]  off;
  logic [31:0] wmask, wbits, rd_val;
  logic [7:0]  sync_val, edges, pend_clr;
  logic        tpend_clr;

  always_comb begin
    hit      = bus.iomem_valid && !ready_q && (bus.iomem_addr[31:8] == BASE_ADDR[31:8]);
    off      = bus.iomem_addr[7:2];
    wr       = hit && (bus.iomem_wstrb != 4'b0000);
    wmask    = {{8{bus.iomem_wstrb[3]}}, {8{bus.iomem_wstrb[2]}},
                {8{bus.iomem_wstrb[1]}}, {8{bus.iomem_wstrb[0]}}};
    wbits    = bus.iomem_wdata & wmask;
    sync_val = sync_q[SYNC_STAGES-1];
    // a bit fires when it changed and its new level matches the selected polarity
    edges    = (sync_val ^ hist_q) & (sync_val ^ edge_q);
    match    = ten_q && (cnt_q == cmp_q);

    case (off)
      6'h00:   rd_val = {24'b0, porta_q};
      6'h01:   rd_val = {24'b0, sync_val};
      6'h02:   rd_val = {24'b0, ie_q};
      6'h03:   rd_val = {24'b0, edge_q};
      6'h04:   rd_val = {24'b0, pend_q};
      6'h05:   rd_val = {29'b0, tpend_q, tirqen_q, ten_q};
      6'h06:   rd_val = cmp_q;
      6'h07:   rd_val = cnt_q;
      default: rd_val = 32'b0;
    endcase

    porta_d   = porta_q;
    ie_d      = ie_q;
    edge_d    = edge_q;
    ten_d     = ten_q;
    tirqen_d  = tirqen_q;
    cmp_d     = cmp_q;
    pend_clr  = 8'b0;
    tpend_clr = 1'b0;
    cnt_d     = ten_q ? (match ? 32'b0 : cnt_q + 32'd1) : cnt_q;

    if (wr) begin
      case (off)
        6'h00: porta_d = (porta_q & ~wmask[7:0]) | wbits[7:0];
        6'h02: ie_d    = (ie_q    & ~wmask[7:0]) | wbits[7:0];
        6'h03: edge_d  = (edge_q  & ~wmask[7:0]) | wbits[7:0];
        6'h04: pend_clr = wbits[7:0];
        6'h05: begin
          if (bus.iomem_wstrb[0]) begin
            ten_d    = bus.iomem_wdata[0];
            tirqen_d = bus.iomem_wdata[1];
          end
          tpend_clr = wbits[2];
        end
        6'h06: cmp_d = (cmp_q & ~wmask) | wbits;
        // CPU write wins over the increment/wrap; match above still used the old count
        6'h07: cnt_d = (cnt_d & ~wmask) | wbits;
        default: ;
      endcase
    end

    pend_d  = (pend_q & ~pend_clr) | edges;
    tpend_d = (tpend_q & ~tpend_clr) | match;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ready_q     <= 1'b0;
      rdata_q     <= 32'b0;
      porta_q     <= 8'b0;
      ie_q        <= 8'b0;
      edge_q      <= 8'b0;
      pend_q      <= 8'b0;
      ten_q       <= 1'b0;
      tirqen_q    <= 1'b0;
      tpend_q     <= 1'b0;
      cmp_q       <= 32'hFFFF_FFFF;
      cnt_q       <= 32'b0;
      sync_q      <= '0;
      hist_q      <= 8'b0;
      irq_gpio_q  <= 1'b0;
      irq_timer_q <= 1'b0;
    end else begin
      ready_q     <= hit;
      rdata_q     <= hit ? rd_val : 32'b0;
      porta_q     <= porta_d;
      ie_q        <= ie_d;
      edge_q      <= edge_d;
      pend_q      <= pend_d;
      ten_q       <= ten_d;
      tirqen_q    <= tirqen_d;
      tpend_q     <= tpend_d;
      cmp_q       <= cmp_d;
      cnt_q       <= cnt_d;
      sync_q      <= {sync_q[SYNC_STAGES-2:0], portb_in};
      hist_q      <= sync_val;
      irq_gpio_q  <= |(pend_q & ie_q);
      irq_timer_q <= tpend_q & tirqen_q;
    end
  end

  assign bus.iomem_ready = ready_q;
  assign bus.iomem_rdata = rdata_q;
  assign porta_out       = porta_q;
  assign irq_gpio        = irq_gpio_q;
  assign irq_timer       = irq_timer_q;

  logic unused_addr;
  assign unused_addr = ^bus.iomem_addr[1:0];

endmodule

// File: tb/tb_iomem_gpio_timer.sv
// Directed bench for iomem_gpio_timer: bus reads are scored against a queue of expected data.
module tb_iomem_gpio_timer;
  localparam int SYNC = 2;
  localparam logic [31:0] B = 32'h0300_0000;

  logic       clk = 0;
  logic       reset = 1;
  logic [7:0] porta_out;
  logic [7:0] portb_in = 8'h00;
  logic       irq_gpio, irq_timer;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  iomem_gpio_timer_if bus_if();

  iomem_gpio_timer #(.BASE_ADDR(B), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .reset(reset), .bus(bus_if.slave),
    .porta_out(porta_out), .portb_in(portb_in),
    .irq_gpio(irq_gpio), .irq_timer(irq_timer)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // one bus access; n = cycle in which the request is accepted
  task automatic bus(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st,
                     input logic [31:0] exp, input bit do_chk, input string tag, output int n);
    int waited = 0;
    bit got = 0;
    logic [31:0] e;
    string t;
    @(negedge clk);
    bus_if.iomem_valid = 1'b1;
    bus_if.iomem_addr  = a;
    bus_if.iomem_wdata = wd;
    bus_if.iomem_wstrb = st;
    n = cyc;
    if (do_chk) begin exp_q.push_back(exp); tag_q.push_back(tag); end
    while (!got && waited < 20) begin
      @(posedge clk); #1;
      waited++;
      if (bus_if.iomem_ready) got = 1;
    end
    chk({tag, "_latency"}, 32'(waited), 32'd1);
    if (do_chk) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      if (got) chk(t, bus_if.iomem_rdata, e);
    end
    @(negedge clk);
    bus_if.iomem_valid = 1'b0;
    bus_if.iomem_wstrb = 4'b0;
  endtask

  task automatic rd(input logic [7:0] off, input logic [31:0] exp, input string tag);
    int n;
    bus(B | 32'(off), 32'b0, 4'b0000, exp, 1'b1, tag, n);
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] d, input logic [3:0] st,
                    input string tag);
    int n;
    bus(B | 32'(off), d, st, 32'b0, 1'b0, tag, n);
  endtask

  function automatic int tcnt(input int c, input int w);
    return (c - w - 1) % 5;
  endfunction

  initial begin
    int  w, n;
    bit  saw;
    bus_if.iomem_valid = 0;
    bus_if.iomem_wstrb = 0;
    bus_if.iomem_addr  = 0;
    bus_if.iomem_wdata = 0;

    // reset
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 0;
    @(posedge clk); #1;
    chk("rst_porta", 32'(porta_out), 32'h0);
    chk("rst_ready", 32'(bus_if.iomem_ready), 32'h0);
    chk("rst_rdata", bus_if.iomem_rdata, 32'h0);
    chk("rst_irq", {30'b0, irq_gpio, irq_timer}, 32'h0);
    rd(8'h18, 32'hFFFF_FFFF, "rst_cmp");
    rd(8'h1C, 32'h0, "rst_cnt");

    // porta byte enables, portb sync
    wr(8'h00, 32'h1234_56A5, 4'b0001, "wr_porta");
    chk("porta_a5", 32'(porta_out), 32'hA5);
    wr(8'h00, 32'h0000_FF00, 4'b0010, "wr_porta_b1");
    chk("porta_keep", 32'(porta_out), 32'hA5);
    rd(8'h03, 32'hA5, "rd_porta_unaligned");
    @(negedge clk); portb_in = 8'hAF;
    repeat (SYNC + 2) @(posedge clk);
    rd(8'h04, 32'hAF, "rd_portb");
    rd(8'h10, 32'hAF, "pend_rise_ie0");
    chk("irq_gpio_ie0", 32'(irq_gpio), 32'h0);
    @(negedge clk); portb_in = 8'h00;
    repeat (SYNC + 3) @(posedge clk);
    wr(8'h10, 32'hFF, 4'b0001, "clr_pend");
    rd(8'h10, 32'h00, "pend_cleared");

    // gpio edges
    wr(8'h08, 32'h01, 4'b0001, "wr_ie");
    wr(8'h0C, 32'h00, 4'b0001, "wr_edge0");
    rd(8'h08, 32'h01, "rd_ie");
    @(negedge clk); portb_in = 8'h01;
    repeat (SYNC + 3) @(posedge clk); #1;
    chk("irq_gpio_rise", 32'(irq_gpio), 32'h1);
    rd(8'h10, 32'h01, "pend_rise");
    wr(8'h10, 32'h01, 4'b0000 | 4'b0001, "w1c_pend");
    repeat (2) @(posedge clk); #1;
    chk("irq_gpio_clr", 32'(irq_gpio), 32'h0);
    @(negedge clk); portb_in = 8'h00;
    repeat (SYNC + 3) @(posedge clk);
    rd(8'h10, 32'h00, "no_pend_fall");
    wr(8'h0C, 32'h01, 4'b0001, "wr_edge1");
    @(negedge clk); portb_in = 8'h01;
    repeat (SYNC + 3) @(posedge clk);
    rd(8'h10, 32'h00, "no_pend_rise_e1");
    @(negedge clk); portb_in = 8'h00;
    repeat (SYNC + 3) @(posedge clk); #1;
    chk("irq_gpio_fall", 32'(irq_gpio), 32'h1);
    rd(8'h10, 32'h01, "pend_fall");

    // timer
    wr(8'h18, 32'h4, 4'b1111, "wr_cmp");
    wr(8'h1C, 32'h0, 4'b1111, "wr_cnt");
    bus(B | 32'h14, 32'h3, 4'b0001, 32'b0, 1'b0, "wr_ctrl", w);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      bus(B | 32'h1C, 32'b0, 4'b0000, 32'(tcnt(cyc, w)), 1'b1, "rd_cnt_seq", n);
    end
    rd(8'h14, 32'h7, "ctrl_pend");
    chk("irq_timer_set", 32'(irq_timer), 32'h1);
    @(posedge clk); #1;
    while (tcnt(cyc, w) != 1) begin @(posedge clk); #1; end
    bus(B | 32'h14, 32'h7, 4'b0001, 32'b0, 1'b0, "w1c_tpend", n);
    rd(8'h14, 32'h3, "ctrl_pend_clr");
    chk("irq_timer_clr", 32'(irq_timer), 32'h0);
    @(posedge clk); #1;
    while (tcnt(cyc, w) != 4) begin @(posedge clk); #1; end
    bus(B | 32'h14, 32'h7, 4'b0001, 32'b0, 1'b0, "w1c_at_match", n);
    rd(8'h14, 32'h7, "set_wins");

    // window miss and unmapped offset
    @(negedge clk);
    bus_if.iomem_valid = 1; bus_if.iomem_addr = B + 32'h100; bus_if.iomem_wstrb = 0;
    saw = 0;
    repeat (10) begin @(posedge clk); #1; if (bus_if.iomem_ready) saw = 1; end
    chk("miss_noready", 32'(saw), 32'h0);
    @(negedge clk); bus_if.iomem_valid = 0;
    wr(8'h40, 32'hDEAD_BEEF, 4'b1111, "wr_hole");
    rd(8'h40, 32'h0, "rd_hole");
    chk("hole_porta", 32'(porta_out), 32'hA5);

    // reset during an access
    @(negedge clk);
    bus_if.iomem_valid = 1; bus_if.iomem_addr = B; bus_if.iomem_wdata = 32'h5A;
    bus_if.iomem_wstrb = 4'b0001; reset = 1;
    saw = 0;
    repeat (3) begin @(posedge clk); #1; if (bus_if.iomem_ready) saw = 1; end
    @(negedge clk); bus_if.iomem_valid = 0; bus_if.iomem_wstrb = 0; reset = 0;
    @(posedge clk); #1;
    if (bus_if.iomem_ready) saw = 1;
    chk("rst_mid_noready", 32'(saw), 32'h0);
    chk("rst_mid_porta", 32'(porta_out), 32'h0);
    rd(8'h18, 32'hFFFF_FFFF, "rst_mid_cmp");

    chk("sb_empty", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
